// File: rtl/state_pkg.sv
// ---------------------------------------------------------------------------
// state_pkg
// Shared types and constants for the traffic-light monitor.
//   state_t : observed car-light encoding (2'b11 is an illegal encoding)
//   seq_t   : progress through a GREEN->YELLOW->RED->GREEN car cycle
//   DWELL_W : width of the saturating dwell counter
// ---------------------------------------------------------------------------
package state_pkg;

  localparam int unsigned DWELL_W = 16;

  typedef enum logic [1:0] {
    RED    = 2'd0,
    YELLOW = 2'd1,
    GREEN  = 2'd2
  } state_t;

  // SEQ_GY: last legal change was GREEN->YELLOW
  // SEQ_YR: GREEN->YELLOW followed by YELLOW->RED, a RED->GREEN completes a cycle
  typedef enum logic [1:0] {
    SEQ_NONE = 2'd0,
    SEQ_GY   = 2'd1,
    SEQ_YR   = 2'd2
  } seq_t;

endpackage

// File: rtl/dwell_counter.sv
// ---------------------------------------------------------------------------
// dwell_counter
// Saturating count of consecutive samples of one car-light value.
//   i_clk     : clock, rising edge
//   i_rst     : synchronous active-high reset, count -> 0
//   i_restart : value changed on this sample, count -> 1
//   i_enable  : same value sampled again, count increments (saturates at all-ones)
//   o_count   : current dwell
// ---------------------------------------------------------------------------
module dwell_counter
  import state_pkg::*;
#(
  parameter int unsigned WIDTH = DWELL_W
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_restart,
  input  logic             i_enable,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_restart) begin
      r_count <= WIDTH'(1);
    end else if (i_enable && (r_count != '1)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/light_monitor.sv
// ---------------------------------------------------------------------------
// light_monitor
// Passive checker for a traffic-light controller. Samples the observed lights
// every rising clk edge and flags protocol violations one cycle later.
//
// Ports
//   clk              : clock, rising edge
//   rst              : synchronous active-high reset
//   car_light[1:0]   : observed car light (state_t; 2'b11 illegal)
//   pedestrian_light : 1 = walk, 0 = red
//   pedestrian_btn   : pedestrian request button
//   conflict_err     : walk shown while cars not red (1-cycle pulse)
//   seq_err          : illegal car transition / encoding (1-cycle pulse)
//   timing_err       : car dwell violation (1-cycle pulse)
//   starve_err       : pedestrian wait overrun (1-cycle pulse)
//   err_any          : sticky OR of all error pulses, cleared by rst
//   cycle_cnt[15:0]  : completed GREEN->YELLOW->RED->GREEN cycles (saturating)
//
// Build option
//   LIGHT_MONITOR_STARVE_EN : when defined, enables the pedestrian starvation
//   check; otherwise starve_err is 0 and pedestrian_btn is ignored.
// ---------------------------------------------------------------------------
module light_monitor
  import state_pkg::*;
#(
  parameter int unsigned GREEN_MIN  = 3,
  parameter int unsigned GREEN_MAX  = 4,
  parameter int unsigned YELLOW_LEN = 2,
  parameter int unsigned WAIT_MAX   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  car_light,
  input  logic        pedestrian_light,
  input  logic        pedestrian_btn,
  output logic        conflict_err,
  output logic        seq_err,
  output logic        timing_err,
  output logic        starve_err,
  output logic        err_any,
  output logic [15:0] cycle_cnt
);

  localparam logic [DWELL_W-1:0] L_GREEN_MIN  = DWELL_W'(GREEN_MIN);
  localparam logic [DWELL_W-1:0] L_GREEN_MAX  = DWELL_W'(GREEN_MAX);
  localparam logic [DWELL_W-1:0] L_YELLOW_LEN = DWELL_W'(YELLOW_LEN);

  state_t               r_prev;
  seq_t                 r_seq;
  seq_t                 w_seq_next;
  logic [DWELL_W-1:0]   w_dwell;
  logic                 w_bad;
  logic                 w_change;
  logic                 w_legal;
  logic                 w_conflict;
  logic                 w_seq;
  logic                 w_timing;
  logic                 w_starve;
  logic                 w_cycle_inc;
  state_t               w_car;

  logic                 r_conflict_err;
  logic                 r_seq_err;
  logic                 r_timing_err;
  logic                 r_starve_err;
  logic                 r_err_any;
  logic [15:0]          r_cycle_cnt;

  // ---------------------------------------------------------------------
  // Sample classification
  // ---------------------------------------------------------------------
  assign w_bad    = (car_light == 2'b11);
  assign w_car    = state_t'(car_light);
  assign w_change = !w_bad && (w_car != r_prev);
  assign w_legal  = ((r_prev == GREEN)  && (w_car == YELLOW)) ||
                    ((r_prev == YELLOW) && (w_car == RED))    ||
                    ((r_prev == RED)    && (w_car == GREEN));

  assign w_conflict = pedestrian_light && (car_light != RED);
  assign w_seq      = w_bad || (w_change && !w_legal);

  // Dwell is the run length of r_prev up to the previous sample. The long
  // green check fires when this sample would make it GREEN_MAX+1; since the
  // count only grows while green persists, that equality occurs once per run.
  assign w_timing =
      (w_change && (r_prev == GREEN)  && (w_dwell <  L_GREEN_MIN))  ||
      (w_change && (r_prev == YELLOW) && (w_dwell != L_YELLOW_LEN)) ||
      (!w_bad && !w_change && (w_car == GREEN) && (w_dwell == L_GREEN_MAX));

  // ---------------------------------------------------------------------
  // Dwell tracking; an illegal encoding neither restarts nor advances it
  // ---------------------------------------------------------------------
  dwell_counter #(
    .WIDTH (DWELL_W)
  ) u_dwell (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_restart (w_change),
    .i_enable  (!w_bad && !w_change),
    .o_count   (w_dwell)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev <= RED;
    end else if (!w_bad) begin
      r_prev <= w_car;
    end
  end

  // ---------------------------------------------------------------------
  // Car cycle sequence tracker
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_seq <= SEQ_NONE;
    end else begin
      r_seq <= w_seq_next;
    end
  end

  always_comb begin
    w_seq_next  = r_seq;
    w_cycle_inc = 1'b0;
    if (w_seq) begin
      w_seq_next = SEQ_NONE;
    end else if (w_change) begin
      case (w_car)
        YELLOW:  w_seq_next = SEQ_GY;
        RED:     w_seq_next = (r_seq == SEQ_GY) ? SEQ_YR : SEQ_NONE;
        GREEN: begin
          w_cycle_inc = (r_seq == SEQ_YR);
          w_seq_next  = SEQ_NONE;
        end
        default: w_seq_next = SEQ_NONE;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Pedestrian starvation check
  // ---------------------------------------------------------------------
`ifdef LIGHT_MONITOR_STARVE_EN
  localparam int unsigned         WAIT_W     = $clog2(WAIT_MAX + 2);
  localparam logic [WAIT_W-1:0]   L_WAIT_MAX = WAIT_W'(WAIT_MAX);
  localparam logic [WAIT_W-1:0]   L_WAIT_LIM = WAIT_W'(WAIT_MAX + 1);

  logic              r_req;
  logic [WAIT_W-1:0] r_wait;
  logic              w_wait_active;

  // A request counts on the sample it is raised; the counter parks at
  // WAIT_MAX+1 so the overrun is flagged only once per request.
  assign w_wait_active = !pedestrian_light && (r_req || pedestrian_btn);
  assign w_starve      = w_wait_active && (r_wait == L_WAIT_MAX);

  always_ff @(posedge clk) begin
    if (rst || pedestrian_light) begin
      r_req  <= 1'b0;
      r_wait <= '0;
    end else if (w_wait_active) begin
      r_req <= 1'b1;
      if (r_wait != L_WAIT_LIM) begin
        r_wait <= r_wait + 1'b1;
      end
    end
  end
`else
  logic w_unused_btn;
  assign w_unused_btn = pedestrian_btn;
  assign w_starve     = 1'b0;
`endif

  // ---------------------------------------------------------------------
  // Registered outputs
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_conflict_err <= 1'b0;
      r_seq_err      <= 1'b0;
      r_timing_err   <= 1'b0;
      r_starve_err   <= 1'b0;
      r_err_any      <= 1'b0;
      r_cycle_cnt    <= '0;
    end else begin
      r_conflict_err <= w_conflict;
      r_seq_err      <= w_seq;
      r_timing_err   <= w_timing;
      r_starve_err   <= w_starve;
      r_err_any      <= r_err_any | w_conflict | w_seq | w_timing | w_starve;
      if (w_cycle_inc && (r_cycle_cnt != '1)) begin
        r_cycle_cnt <= r_cycle_cnt + 1'b1;
      end
    end
  end

  assign conflict_err = r_conflict_err;
  assign seq_err      = r_seq_err;
  assign timing_err   = r_timing_err;
  assign starve_err   = r_starve_err;
  assign err_any      = r_err_any;
  assign cycle_cnt    = r_cycle_cnt;

endmodule

// File: tb/tb_light_monitor.sv
// ---------------------------------------------------------------------------
// tb_light_monitor
// Self-checking bench for light_monitor: fixed vector table, a starvation
// sequence, then randomized traffic compared against a history-based model.
// ---------------------------------------------------------------------------
module tb_light_monitor;

  localparam int unsigned GREEN_MIN  = 3;
  localparam int unsigned GREEN_MAX  = 4;
  localparam int unsigned YELLOW_LEN = 2;
  localparam int unsigned WAIT_MAX   = 16;

  localparam logic [1:0] C_R = 2'd0;
  localparam logic [1:0] C_Y = 2'd1;
  localparam logic [1:0] C_G = 2'd2;
  localparam logic [1:0] C_X = 2'd3;

`ifdef LIGHT_MONITOR_STARVE_EN
  localparam bit STARVE_ON = 1'b1;
`else
  localparam bit STARVE_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  car_light;
  logic        pedestrian_light;
  logic        pedestrian_btn;
  logic        conflict_err;
  logic        seq_err;
  logic        timing_err;
  logic        starve_err;
  logic        err_any;
  logic [15:0] cycle_cnt;

  always #5 clk = ~clk;

  light_monitor #(
    .GREEN_MIN  (GREEN_MIN),
    .GREEN_MAX  (GREEN_MAX),
    .YELLOW_LEN (YELLOW_LEN),
    .WAIT_MAX   (WAIT_MAX)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .car_light        (car_light),
    .pedestrian_light (pedestrian_light),
    .pedestrian_btn   (pedestrian_btn),
    .conflict_err     (conflict_err),
    .seq_err          (seq_err),
    .timing_err       (timing_err),
    .starve_err       (starve_err),
    .err_any          (err_any),
    .cycle_cnt        (cycle_cnt)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Keeps the accepted car-sample history and the list of recent legal
  // transitions; dwell is the run length at the end of the history.
  int hist[$];
  int ev[$];
  int m_cnt;
  bit m_any;
  int n_smp;
  int req_t;
  bit e_conf, e_seq, e_tim, e_starve;

  function automatic int trail();
    int c = 0;
    int last;
    if (hist.size() == 0) return 0;
    last = hist[hist.size()-1];
    for (int i = hist.size() - 1; i >= 0; i--) begin
      if (hist[i] != last) break;
      c++;
    end
    return c;
  endfunction

  task automatic model_step(input bit r, input int car, input bit pl, input bit btn);
    int  prev;
    int  dw;
    bit  legal;
    if (r) begin
      hist.delete(); ev.delete();
      m_cnt = 0; m_any = 0; n_smp = 0; req_t = -1;
      e_conf = 0; e_seq = 0; e_tim = 0; e_starve = 0;
      return;
    end
    prev = (hist.size() == 0) ? 0 : hist[hist.size()-1];
    dw   = trail();
    e_conf = pl && (car != 0);
    e_seq = 0; e_tim = 0; e_starve = 0;
    if (car == 3) begin
      e_seq = 1;
      ev.delete();
    end else if (car != prev) begin
      legal = (prev == 2 && car == 1) || (prev == 1 && car == 0) || (prev == 0 && car == 2);
      if (!legal) begin
        e_seq = 1;
        ev.delete();
      end else begin
        if (car == 2 && ev.size() >= 2 && ev[ev.size()-2] == 21 && ev[ev.size()-1] == 10
            && m_cnt < 65535)
          m_cnt++;
        ev.push_back(prev * 10 + car);
        if (ev.size() > 4) void'(ev.pop_front());
      end
      if (prev == 2 && dw < int'(GREEN_MIN)) e_tim = 1;
      if (prev == 1 && dw != int'(YELLOW_LEN)) e_tim = 1;
      hist.push_back(car);
    end else begin
      hist.push_back(car);
      if (car == 2 && dw + 1 == int'(GREEN_MAX) + 1) e_tim = 1;
    end
    if (hist.size() > 200) void'(hist.pop_front());
    if (STARVE_ON) begin
      if (pl) req_t = -1;
      else begin
        if (req_t < 0 && btn) req_t = n_smp;
        if (req_t >= 0 && (n_smp - req_t + 1) == int'(WAIT_MAX) + 1) e_starve = 1;
      end
    end
    n_smp++;
    m_any = m_any | e_conf | e_seq | e_tim | e_starve;
  endtask

  // Drive one sample, let it be taken, then look at the outputs 1 time unit later.
  task automatic apply(input bit r, input logic [1:0] car, input bit pl, input bit btn);
    rst = r; car_light = car; pedestrian_light = pl; pedestrian_btn = btn;
    @(posedge clk);
    model_step(r, int'(car), pl, btn);
    #1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit         r;
    logic [1:0] car;
    bit         pl;
    bit         conf, sq, tim, any;
    int         cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(bit r, logic [1:0] car, bit pl, bit conf, bit sq, bit tim,
                             bit any, int cnt);
    vec_t x;
    x.r = r; x.car = car; x.pl = pl;
    x.conf = conf; x.sq = sq; x.tim = tim; x.any = any; x.cnt = cnt;
    return x;
  endfunction

  initial begin
    int gs;
    int rem;
    logic [1:0] car;
    bit pl, btn, r;

    rst = 1'b1; car_light = C_R; pedestrian_light = 1'b0; pedestrian_btn = 1'b0;

    //             r  car  pl conf seq tim any cnt
    // legal run, one complete cycle
    tbl.push_back(v(1, C_R, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, C_G, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, C_G, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, C_G, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, C_Y, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, C_Y, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, C_R, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, C_R, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, C_R, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, C_G, 0, 0, 0, 0, 0, 1));
    // conflict for two samples, err_any sticks
    tbl.push_back(v(0, C_G, 1, 1, 0, 0, 1, 1));
    tbl.push_back(v(0, C_G, 1, 1, 0, 0, 1, 1));
    tbl.push_back(v(0, C_G, 0, 0, 0, 0, 1, 1));
    // G->R illegal (also short green), then illegal encoding
    tbl.push_back(v(1, C_R, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, C_G, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, C_R, 0, 0, 1, 1, 1, 0));
    tbl.push_back(v(0, C_X, 0, 0, 1, 0, 1, 0));
    tbl.push_back(v(0, C_R, 0, 0, 0, 0, 1, 0));
    // short green, Y->G (illegal + short yellow), long green, then a cycle
    tbl.push_back(v(1, C_R, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, C_G, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, C_G, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, C_Y, 0, 0, 0, 1, 1, 0));
    tbl.push_back(v(0, C_G, 0, 0, 1, 1, 1, 0));
    tbl.push_back(v(0, C_G, 0, 0, 0, 0, 1, 0));
    tbl.push_back(v(0, C_G, 0, 0, 0, 0, 1, 0));
    tbl.push_back(v(0, C_G, 0, 0, 0, 0, 1, 0));
    tbl.push_back(v(0, C_G, 0, 0, 0, 1, 1, 0));
    tbl.push_back(v(0, C_Y, 0, 0, 0, 0, 1, 0));
    tbl.push_back(v(0, C_Y, 0, 0, 0, 0, 1, 0));
    tbl.push_back(v(0, C_R, 0, 0, 0, 0, 1, 0));
    tbl.push_back(v(0, C_G, 0, 0, 0, 0, 1, 1));
    // long yellow
    tbl.push_back(v(0, C_G, 0, 0, 0, 0, 1, 1));
    tbl.push_back(v(0, C_G, 0, 0, 0, 0, 1, 1));
    tbl.push_back(v(0, C_Y, 0, 0, 0, 0, 1, 1));
    tbl.push_back(v(0, C_Y, 0, 0, 0, 0, 1, 1));
    tbl.push_back(v(0, C_Y, 0, 0, 0, 0, 1, 1));
    tbl.push_back(v(0, C_R, 0, 0, 0, 1, 1, 1));
    // reset mid-yellow, then fresh green
    tbl.push_back(v(1, C_R, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, C_G, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, C_G, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, C_G, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, C_Y, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(1, C_Y, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, C_G, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, C_G, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, C_G, 0, 0, 0, 0, 0, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i].r, tbl[i].car, tbl[i].pl, 1'b0);
      chk($sformatf("tbl%0d conflict", i), {15'd0, conflict_err}, {15'd0, tbl[i].conf});
      chk($sformatf("tbl%0d seq", i),      {15'd0, seq_err},      {15'd0, tbl[i].sq});
      chk($sformatf("tbl%0d timing", i),   {15'd0, timing_err},   {15'd0, tbl[i].tim});
      chk($sformatf("tbl%0d starve", i),   {15'd0, starve_err},   16'd0);
      chk($sformatf("tbl%0d err_any", i),  {15'd0, err_any},      {15'd0, tbl[i].any});
      chk($sformatf("tbl%0d cycle_cnt", i), cycle_cnt,            16'(tbl[i].cnt));
    end

    // Starvation: one button press, walk held off for 20 samples.
    apply(1, C_R, 0, 0);
    for (int k = 1; k <= 20; k++) begin
      apply(0, C_R, 0, k == 1);
      chk($sformatf("starve k=%0d", k), {15'd0, starve_err}, {15'd0, STARVE_ON && (k == 17)});
      chk($sformatf("starve any k=%0d", k), {15'd0, err_any}, {15'd0, STARVE_ON && (k >= 17)});
    end
    // Walk served: request cleared, a new press restarts the full wait.
    apply(0, C_R, 1, 0);
    chk("starve walk", {15'd0, starve_err | conflict_err}, 16'd0);
    for (int k = 1; k <= 18; k++) begin
      apply(0, C_R, 0, k == 1);
      chk($sformatf("starve2 k=%0d", k), {15'd0, starve_err}, {15'd0, STARVE_ON && (k == 17)});
    end

    // Randomized traffic against the model.
    apply(1, C_R, 0, 0);
    gs = 0; rem = 1;
    for (int s = 0; s < 3000; s++) begin
      r = ($urandom_range(0, 299) == 0);
      if (rem == 0) begin
        gs  = (gs == 0) ? 2 : (gs == 2) ? 1 : 0;
        rem = (gs == 2) ? $urandom_range(2, 6) : (gs == 1) ? $urandom_range(1, 3)
                        : $urandom_range(1, 24);
      end
      rem--;
      car = 2'(gs);
      if ($urandom_range(0, 29) == 0) car = 2'($urandom_range(0, 3));
      pl  = (gs == 0) ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 39) == 0);
      btn = ($urandom_range(0, 9) == 0);
      apply(r, car, pl, btn);
      chk("rnd conflict",  {15'd0, conflict_err}, {15'd0, e_conf});
      chk("rnd seq",       {15'd0, seq_err},      {15'd0, e_seq});
      chk("rnd timing",    {15'd0, timing_err},   {15'd0, e_tim});
      chk("rnd starve",    {15'd0, starve_err},   {15'd0, e_starve});
      chk("rnd err_any",   {15'd0, err_any},      {15'd0, m_any});
      chk("rnd cycle_cnt", cycle_cnt,             16'(m_cnt));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
